selector_arbiter: RTL

Round-robin arbiter that shares the 4-bit, 4-input selector datapath between four requesters. It grants one requester at a time for a bounded burst and drives the selector's select lines from registered grant state. It also registers the selected word with a valid flag for the downstream consumer. It sits directly in front of the selector41 mux, which it instantiates.

---
 rtl/selector_arbiter_pkg.sv | 42 ++++
 rtl/selector41.sv | 29 ++
 rtl/selector_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/selector_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : selector_arbiter_pkg
// Description : Shared constants and helpers for the round-robin selector arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package selector_arbiter_pkg;

    localparam int c_idxWidth = 2;
    localparam int c_cntWidth = 3;

    localparam int BURST_DEFAULT = 4;
    localparam int BURST_MIN     = 1;
    localparam int BURST_MAX     = 8;

    localparam logic [0:0] c_stIdle  = 1'b0;
    localparam logic [0:0] c_stGrant = 1'b1;

    // Returns {found, index}; candidates are visited last+1, last+2, last+3, last.
    function automatic logic [c_idxWidth:0] rrPick(input logic [3:0] req,
                                                   input logic [c_idxWidth-1:0] last);
        logic [c_idxWidth:0]   pick;
        logic [c_idxWidth-1:0] cand;
        pick = '0;
        for (int i = 4; i >= 1; i--) begin
            cand = last + c_idxWidth'(i);
            if (req[cand]) begin
                pick = {1'b1, cand};
            end
        end
        return pick;
    endfunction

    function automatic logic [3:0] oneHot(input logic [c_idxWidth-1:0] idx);
        logic [3:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage
`default_nettype wire

// File: rtl/selector41.sv
`default_nettype none
// ============================================================================
// Module      : selector41
// Description : 4-bit, 4-input combinational selector; {iS1,iS0} picks the word.
// Revision    : 1.0 - initial release
// ============================================================================
module selector41 (
    input  logic [3:0] iD0,
    input  logic [3:0] iD1,
    input  logic [3:0] iD2,
    input  logic [3:0] iD3,
    input  logic       iS1,
    input  logic       iS0,
    output logic [3:0] oZ
);

    always_comb begin
        oZ = iD0;
        case ({iS1, iS0})
            2'd0:    oZ = iD0;
            2'd1:    oZ = iD1;
            2'd2:    oZ = iD2;
            2'd3:    oZ = iD3;
            default: oZ = iD0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/selector_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : selector_arbiter
// Description : Round-robin burst arbiter driving a selector41 mux, with a
//               registered output word and valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
module selector_arbiter
    import selector_arbiter_pkg::*;
#(
    parameter int BURST = BURST_DEFAULT  // legal range BURST_MIN..BURST_MAX
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic [3:0] iReq,
    input  logic [3:0] iD0,
    input  logic [3:0] iD1,
    input  logic [3:0] iD2,
    input  logic [3:0] iD3,
    output logic [3:0] oGnt,
    output logic       oS1,
    output logic       oS0,
    output logic [3:0] oZ,
    output logic       oValid
);

    localparam logic [c_cntWidth-1:0] c_burstLast = c_cntWidth'(BURST - 1);

    logic [0:0]            r_state;
    logic [c_idxWidth-1:0] r_gidx;
    logic [c_cntWidth-1:0] r_cnt;
    logic [c_idxWidth-1:0] r_last;
    logic [3:0]            r_gnt;
    logic [3:0]            r_z;
    logic                  r_valid;

    logic [0:0]            w_stateNext;
    logic [c_idxWidth-1:0] w_gidxNext;
    logic [c_cntWidth-1:0] w_cntNext;
    logic [c_idxWidth-1:0] w_lastNext;
    logic [3:0]            w_gntNext;
    logic                  w_xfer;
    logic                  w_endGrant;
    logic [3:0]            w_others;
    logic [c_idxWidth:0]   w_pickAll;
    logic [c_idxWidth:0]   w_pickOthers;
    logic [3:0]            w_muxZ;

    selector41 u_selector41 (
        .iD0 (iD0),
        .iD1 (iD1),
        .iD2 (iD2),
        .iD3 (iD3),
        .iS1 (r_gidx[1]),
        .iS0 (r_gidx[0]),
        .oZ  (w_muxZ)
    );

    always_comb begin
        w_xfer       = (r_state == c_stGrant) && iReq[r_gidx];
        w_endGrant   = !iReq[r_gidx] || (r_cnt == c_burstLast);
        w_others     = iReq & ~oneHot(r_gidx);
        w_pickAll    = rrPick(iReq, r_last);
        w_pickOthers = rrPick(w_others, r_last);

        w_stateNext  = r_state;
        w_gidxNext   = r_gidx;
        w_cntNext    = r_cnt;
        w_lastNext   = r_last;
        w_gntNext    = r_gnt;

        case (r_state)
            c_stIdle: begin
                if (w_pickAll[c_idxWidth]) begin
                    w_stateNext = c_stGrant;
                    w_gidxNext  = w_pickAll[c_idxWidth-1:0];
                    w_lastNext  = w_pickAll[c_idxWidth-1:0];
                    w_gntNext   = oneHot(w_pickAll[c_idxWidth-1:0]);
                    w_cntNext   = '0;
                end else begin
                    w_gntNext   = '0;
                end
            end
            c_stGrant: begin
                if (w_endGrant) begin
                    // Hand over with no idle bubble; the outgoing requester is masked.
                    if (w_pickOthers[c_idxWidth]) begin
                        w_gidxNext = w_pickOthers[c_idxWidth-1:0];
                        w_lastNext = w_pickOthers[c_idxWidth-1:0];
                        w_gntNext  = oneHot(w_pickOthers[c_idxWidth-1:0]);
                        w_cntNext  = '0;
                    end else if (iReq[r_gidx]) begin
                        w_cntNext  = '0;
                    end else begin
                        w_stateNext = c_stIdle;
                        w_gntNext   = '0;
                    end
                end else begin
                    w_cntNext = r_cnt + c_cntWidth'(1);
                end
            end
            default: begin
                w_stateNext = c_stIdle;
                w_gntNext   = '0;
            end
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state <= c_stIdle;
            r_gidx  <= '0;
            r_cnt   <= '0;
            r_last  <= 2'd3;
            r_gnt   <= '0;
            r_z     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_gidx  <= w_gidxNext;
            r_cnt   <= w_cntNext;
            r_last  <= w_lastNext;
            r_gnt   <= w_gntNext;
            r_valid <= w_xfer;
            if (w_xfer) begin
                r_z <= w_muxZ;
            end
        end
    end

    assign oGnt   = r_gnt;
    assign oS1    = r_gidx[1];
    assign oS0    = r_gidx[0];
    assign oZ     = r_z;
    assign oValid = r_valid;

endmodule
`default_nettype wire
